// File: rtl/decode_if.sv
// decode_if: fetch-side inputs and execute-side outputs of the decode stage
interface decode_if #(
  parameter int ALU_W = 14,
  parameter int OPC_W = 11
);
  logic [31:0]      i_pc;
  logic [31:0]      i_instr;
  logic             i_ce;
  logic             i_stall;
  logic             i_flush;
  logic [4:0]       o_rs1_addr_c;
  logic [4:0]       o_rs2_addr_c;
  logic [31:0]      o_pc;
  logic [4:0]       o_rs1_addr;
  logic [4:0]       o_rs2_addr;
  logic [4:0]       o_rd_addr;
  logic [31:0]      o_imm;
  logic [2:0]       o_funct3;
  logic [ALU_W-1:0] o_alu_op;
  logic [OPC_W-1:0] o_opcode;
  logic             o_exception;
  logic             o_ecall;
  logic             o_ebreak;
  logic             o_mret;
  logic             o_ce;
  logic             o_stall;
  logic             o_flush;
  modport slave (
    input  i_pc, i_instr, i_ce, i_stall, i_flush,
    output o_rs1_addr_c, o_rs2_addr_c, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm,
           o_funct3, o_alu_op, o_opcode, o_exception, o_ecall, o_ebreak, o_mret,
           o_ce, o_stall, o_flush
  );
  modport master (
    output i_pc, i_instr, i_ce, i_stall, i_flush,
    input  o_rs1_addr_c, o_rs2_addr_c, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm,
           o_funct3, o_alu_op, o_opcode, o_exception, o_ecall, o_ebreak, o_mret,
           o_ce, o_stall, o_flush
  );
endinterface

// File: rtl/decode.sv
// decode: RV32I decode stage registering fetched PC/instruction and decoding fields
module decode #(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter int          ALU_W    = 14,
  parameter int          OPC_W    = 11
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_SYS = 7'b1110011, OP_FENCE = 7'b0001111;
  logic [31:0]      ins;
  logic [6:0]       op, f7;
  logic [2:0]       f3;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [3:0]       arith_idx, br_idx, alu_idx, cls_idx;
  logic             use_alu, ill, is_ecall, is_ebreak, is_mret;
  logic [ALU_W-1:0] alu_n;
  logic [OPC_W-1:0] opc_n;
  assign ins   = bus.i_instr;
  assign op    = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign is_ecall  = ins == 32'h0000_0073;
  assign is_ebreak = ins == 32'h0010_0073;
  assign is_mret   = ins == 32'h3020_0073;
  // ALU index order: ADD SUB SLT SLTU XOR OR AND SLL SRL SRA EQ NEQ GE GEU
  assign arith_idx = f3 == 3'd0 ? ((op == OP_R && f7[5]) ? 4'd1 : 4'd0) :
                     f3 == 3'd1 ? 4'd7 : f3 == 3'd2 ? 4'd2 : f3 == 3'd3 ? 4'd3 :
                     f3 == 3'd4 ? 4'd4 : f3 == 3'd5 ? (f7[5] ? 4'd9 : 4'd8) :
                     f3 == 3'd6 ? 4'd5 : 4'd6;
  assign br_idx = f3 == 3'd0 ? 4'd10 : f3 == 3'd1 ? 4'd11 : f3 == 3'd4 ? 4'd2 :
                  f3 == 3'd5 ? 4'd12 : f3 == 3'd6 ? 4'd3 : 4'd13;
  always_comb begin
    cls_idx = 4'd0;
    alu_idx = 4'd0;
    use_alu = 1'b1;
    ill     = 1'b0;
    imm     = imm_i;
    case (op)
      OP_R: begin
        imm     = '0;
        alu_idx = arith_idx;
        ill     = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_I: begin
        cls_idx = 4'd1;
        alu_idx = arith_idx;
        ill     = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_LD: begin
        cls_idx = 4'd2;
        ill     = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      OP_ST: begin
        cls_idx = 4'd3;
        imm     = imm_s;
        ill     = f3 > 3'd2;
      end
      OP_BR: begin
        cls_idx = 4'd4;
        imm     = imm_b;
        alu_idx = br_idx;
        ill     = f3 == 3'd2 || f3 == 3'd3;
      end
      OP_JAL: begin
        cls_idx = 4'd5;
        imm     = imm_j;
      end
      OP_JALR: begin
        cls_idx = 4'd6;
        ill     = f3 != 3'd0;
      end
      OP_LUI: begin
        cls_idx = 4'd7;
        imm     = imm_u;
      end
      OP_AUIPC: begin
        cls_idx = 4'd8;
        imm     = imm_u;
      end
      OP_SYS: begin
        cls_idx = 4'd9;
        use_alu = 1'b0;
        ill     = f3 == 3'd0 && !(is_ecall || is_ebreak || is_mret);
      end
      OP_FENCE: begin
        cls_idx = 4'd10;
        use_alu = 1'b0;
      end
      default: ill = 1'b1;
    endcase
  end
  assign opc_n = ill ? '0 : OPC_W'(1) << cls_idx;
  assign alu_n = (ill || !use_alu) ? '0 : ALU_W'(1) << alu_idx;
  assign bus.o_rs1_addr_c = ins[19:15];
  assign bus.o_rs2_addr_c = ins[24:20];
  assign bus.o_stall      = bus.i_stall;
  assign bus.o_flush      = bus.i_flush;
  // a stalled stage ignores flush; bubbles (i_ce=0) only clear o_ce
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_pc        <= PC_RESET;
      bus.o_rs1_addr  <= '0;
      bus.o_rs2_addr  <= '0;
      bus.o_rd_addr   <= '0;
      bus.o_imm       <= '0;
      bus.o_funct3    <= '0;
      bus.o_alu_op    <= '0;
      bus.o_opcode    <= '0;
      bus.o_exception <= 1'b0;
      bus.o_ecall     <= 1'b0;
      bus.o_ebreak    <= 1'b0;
      bus.o_mret      <= 1'b0;
      bus.o_ce        <= 1'b0;
    end else if (!bus.i_stall) begin
      bus.o_ce <= bus.i_ce & ~bus.i_flush;
      if (bus.i_ce) begin
        bus.o_pc        <= bus.i_pc;
        bus.o_rs1_addr  <= ins[19:15];
        bus.o_rs2_addr  <= ins[24:20];
        bus.o_rd_addr   <= ins[11:7];
        bus.o_imm       <= imm;
        bus.o_funct3    <= f3;
        bus.o_alu_op    <= alu_n;
        bus.o_opcode    <= opc_n;
        bus.o_exception <= ill;
        bus.o_ecall     <= is_ecall;
        bus.o_ebreak    <= is_ebreak;
        bus.o_mret      <= is_mret;
      end
    end
  end
endmodule
